wb_arbiter: RTL and testbench

- Shares the single vector-register-file write/retire port among NumPipes functional-unit pipelines.
- Each pipeline is a fixed-latency shift pipe with a global stall that freezes all of its stages.
- Selects one valid pipe output per cycle using round-robin, registers it onto the writeback port, and stalls every pipe that requested but was not accepted.
- Sits between the functional-unit pipes and the register file / reservation-station retire logic.

---
 rtl/wb_arbiter_pkg.sv | 21 ++
 rtl/wb_arbiter_if.sv | 36 +++
 rtl/wb_arbiter_rr_arbiter.sv | 35 +++
 rtl/wb_arbiter.sv | 101 ++++++++++
 tb/tb_wb_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: register-file field types and the latched writeback entry.
package wb_arbiter_pkg;

  localparam int unsigned MaskWidth    = 8;
  localparam int unsigned VRegIdxWidth = 5;
  localparam int unsigned RsvIdWidth   = 4;

  typedef logic [MaskWidth-1:0]    Mask_t;
  typedef logic [VRegIdxWidth-1:0] VRegIdx_t;
  typedef logic [RsvIdWidth-1:0]   RsvID_t;

  // One writeback/retire entry, used both per pipe and for the output register.
  typedef struct packed {
    Mask_t    mask;
    logic     dst_reg_valid;
    VRegIdx_t vid;
    logic     dst_reg_type;
    RsvID_t   rid;
  } WbEntry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Pipe-side requests and register-file writeback port of the arbiter.
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NumPipes = 4
);

  logic     [NumPipes-1:0] iOpValid;
  Mask_t    [NumPipes-1:0] iMask;
  logic     [NumPipes-1:0] iDstRegValid;
  VRegIdx_t [NumPipes-1:0] iDstRegVID;
  logic     [NumPipes-1:0] iDstRegType;
  RsvID_t   [NumPipes-1:0] iRID;
  logic     [NumPipes-1:0] oStall;

  logic     iWbReady;
  logic     oWbValid;
  logic     oWbWe;
  Mask_t    oWbMask;
  VRegIdx_t oWbVID;
  logic     oWbType;
  RsvID_t   oWbRID;

  // Pipes and register file side.
  modport master (
    output iOpValid, iMask, iDstRegValid, iDstRegVID, iDstRegType, iRID, iWbReady,
    input  oStall, oWbValid, oWbWe, oWbMask, oWbVID, oWbType, oWbRID
  );

  // Arbiter side.
  modport slave (
    input  iOpValid, iMask, iDstRegValid, iDstRegVID, iDstRegType, iRID, iWbReady,
    output oStall, oWbValid, oWbWe, oWbMask, oWbVID, oWbType, oWbRID
  );

endinterface

// File: rtl/wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping modulo N.
module rr_arbiter #(
  parameter  int unsigned N    = 4,
  localparam int unsigned PtrW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [PtrW-1:0] winner_o,
  output logic            any_req_o
);

  logic [PtrW:0] idx;

  // Scan from the farthest slot back to ptr_i so the closest requester wins last.
  always_comb begin
    any_req_o = |req_i;
    winner_o  = ptr_i;
    idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_i} + (PtrW + 1)'(k);
      if (idx >= (PtrW + 1)'(N)) begin
        idx = idx - (PtrW + 1)'(N);
      end
      if (req_i[idx[PtrW-1:0]]) begin
        winner_o = idx[PtrW-1:0];
      end
    end
    grant_o = '0;
    if (any_req_o) begin
      grant_o[winner_o] = 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one register-file writeback/retire port among NumPipes pipes.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NumPipes = 4,
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk,
  input  logic                rst,
  wb_arbiter_if.slave         bus,
  output logic [CntWidth-1:0] oConflictCnt
);

  localparam int unsigned PtrW = $clog2(NumPipes);

  logic     [NumPipes-1:0] req;
  logic     [NumPipes-1:0] grant_rr;
  logic     [NumPipes-1:0] grant;
  logic     [PtrW-1:0]     winner;
  logic                    any_req;
  logic                    accept;
  WbEntry_t [NumPipes-1:0] pipe_entry;

  logic                valid_q, valid_d;
  WbEntry_t            entry_q, entry_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  assign req    = bus.iOpValid;
  assign accept = !rst && (!valid_q || bus.iWbReady);

  rr_arbiter #(.N(NumPipes)) u_rr (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .grant_o   (grant_rr),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  // A pipe is frozen whenever it has an op that was not taken this cycle.
  assign grant      = accept ? grant_rr : '0;
  assign bus.oStall = req & ~grant;

  // Gather each pipe's fields into an entry bundle.
  always_comb begin
    pipe_entry = '0;
    for (int i = 0; i < NumPipes; i++) begin
      pipe_entry[i].mask          = bus.iMask[i];
      pipe_entry[i].dst_reg_valid = bus.iDstRegValid[i];
      pipe_entry[i].vid           = bus.iDstRegVID[i];
      pipe_entry[i].dst_reg_type  = bus.iDstRegType[i];
      pipe_entry[i].rid           = bus.iRID[i];
    end
  end

  // Next state for the output entry, round-robin pointer and conflict counter.
  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (accept) begin
      valid_d = any_req;
      if (any_req) begin
        entry_d = pipe_entry[winner];
        ptr_d   = (winner == PtrW'(NumPipes - 1)) ? '0 : winner + 1'b1;
      end
    end
    // Two or more bits set iff clearing the lowest set bit leaves something.
    if (((req & (req - 1'b1)) != '0) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Control state; reset drops any latched entry without retiring it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Entry payload is don't-care while invalid, so it carries no reset.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  assign bus.oWbValid = valid_q;
  assign bus.oWbWe    = valid_q && entry_q.dst_reg_valid;
  assign bus.oWbMask  = entry_q.mask;
  assign bus.oWbVID   = entry_q.vid;
  assign bus.oWbType  = entry_q.dst_reg_type;
  assign bus.oWbRID   = entry_q.rid;
  assign oConflictCnt = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: per-cycle reference model plus directed scenarios with literal expectations.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int unsigned NP = 4;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] oConflictCnt;

  int total = 0;
  int bad   = 0;

  wb_arbiter_if #(.NumPipes(NP)) bus ();

  wb_arbiter #(.NumPipes(NP), .CntWidth(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .oConflictCnt (oConflictCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    for (int i = 0; i < NP; i++) begin
      bus.iMask[i]        = Mask_t'(8'h11 * (i + 1));
      bus.iDstRegValid[i] = 1'b1;
      bus.iDstRegVID[i]   = VRegIdx_t'(i + 16);
      bus.iDstRegType[i]  = i[0];
      bus.iRID[i]         = RsvID_t'(i + 8);
    end
  endtask

  // Reference model: last-granted pipe, held entry and saturating conflict count.
  logic     m_init = 1'b0;
  logic     m_valid;
  int       m_last;
  int       m_cnt;
  Mask_t    m_mask;
  logic     m_dv;
  VRegIdx_t m_vid;
  logic     m_type;
  RsvID_t   m_rid;

  always @(negedge clk) begin
    int              win;
    logic            acc;
    logic [NP-1:0]   rq;
    logic [NP-1:0]   exp_stall;
    rq  = bus.iOpValid;
    acc = !rst && (!m_valid || bus.iWbReady);
    win = -1;
    for (int k = 1; k <= NP; k++) begin
      int j;
      j = (m_last + k) % NP;
      if (win < 0 && rq[j]) win = j;
    end
    for (int i = 0; i < NP; i++) exp_stall[i] = rq[i] && !(acc && win == i);
    if (m_init) begin
      check("m_stall", 32'(bus.oStall), 32'(exp_stall));
      check("m_valid", 32'(bus.oWbValid), 32'(m_valid));
      check("m_cnt", 32'(oConflictCnt), 32'(m_cnt));
      if (m_valid) begin
        check("m_we", 32'(bus.oWbWe), 32'(m_dv));
        check("m_rid", 32'(bus.oWbRID), 32'(m_rid));
        check("m_vid", 32'(bus.oWbVID), 32'(m_vid));
        check("m_mask", 32'(bus.oWbMask), 32'(m_mask));
        check("m_type", 32'(bus.oWbType), 32'(m_type));
      end
    end
    if (rst) begin
      m_init  = 1'b1;
      m_valid = 1'b0;
      m_last  = NP - 1;
      m_cnt   = 0;
    end else if (m_init) begin
      if (acc) begin
        if (win >= 0) begin
          m_valid = 1'b1;
          m_last  = win;
          m_mask  = bus.iMask[win];
          m_dv    = bus.iDstRegValid[win];
          m_vid   = bus.iDstRegVID[win];
          m_type  = bus.iDstRegType[win];
          m_rid   = bus.iRID[win];
        end else begin
          m_valid = 1'b0;
        end
      end
      if ($countones(rq) >= 2 && m_cnt < (2 ** CW) - 1) m_cnt = m_cnt + 1;
    end
  end

  initial begin
    rst          = 1'b1;
    bus.iOpValid = '0;
    bus.iWbReady = 1'b1;
    set_defaults();
    tick();
    tick();
    @(negedge clk);
    check("rst_valid", 32'(bus.oWbValid), 32'd0);
    check("rst_cnt", 32'(oConflictCnt), 32'd0);

    // Single requester on pipe 2.
    tick();
    rst                 = 1'b0;
    bus.iOpValid        = 4'b0100;
    bus.iRID[2]         = 4'd5;
    bus.iDstRegVID[2]   = 5'd12;
    bus.iDstRegValid[2] = 1'b1;
    @(negedge clk);
    check("single_stall", 32'(bus.oStall), 32'h0);
    tick();
    bus.iOpValid = '0;
    @(negedge clk);
    check("single_valid", 32'(bus.oWbValid), 32'd1);
    check("single_we", 32'(bus.oWbWe), 32'd1);
    check("single_rid", 32'(bus.oWbRID), 32'd5);
    check("single_vid", 32'(bus.oWbVID), 32'd12);
    tick();
    set_defaults();

    // All four requesting from ptr=0: grants 0,1,2,3,0.
    rst = 1'b1;
    tick();
    rst          = 1'b0;
    bus.iOpValid = 4'b1111;
    @(negedge clk);
    check("rr_stall_first", 32'(bus.oStall), 32'hE);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      check("rr_rid", 32'(bus.oWbRID), 32'(8 + ((n - 1) % 4)));
      check("rr_cnt", 32'(oConflictCnt), 32'(n));
      check("rr_stall_pop", 32'($countones(bus.oStall)), 32'd3);
    end

    // Backpressure: pipe 1 entry held for three cycles, then exactly one load.
    tick();
    bus.iOpValid = 4'b0011;
    bus.iWbReady = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("bp_stall", 32'(bus.oStall), 32'h3);
      check("bp_rid", 32'(bus.oWbRID), 32'd9);
      check("bp_valid", 32'(bus.oWbValid), 32'd1);
    end
    tick();
    bus.iWbReady = 1'b1;
    @(negedge clk);
    check("bp_release_stall", 32'(bus.oStall), 32'h2);
    tick();
    bus.iWbReady = 1'b0;
    @(negedge clk);
    check("bp_load_rid", 32'(bus.oWbRID), 32'd8);
    check("bp_load_stall", 32'(bus.oStall), 32'h3);
    tick();
    @(negedge clk);
    check("bp_one_load", 32'(bus.oWbRID), 32'd8);

    // Non-writing op on pipe 3 still retires its RID.
    tick();
    bus.iOpValid        = 4'b1000;
    bus.iDstRegValid[3] = 1'b0;
    bus.iRID[3]         = 4'd7;
    bus.iWbReady        = 1'b1;
    @(negedge clk);
    check("nw_stall", 32'(bus.oStall), 32'h0);
    tick();
    bus.iOpValid = '0;
    @(negedge clk);
    check("nw_valid", 32'(bus.oWbValid), 32'd1);
    check("nw_we", 32'(bus.oWbWe), 32'd0);
    check("nw_rid", 32'(bus.oWbRID), 32'd7);
    tick();
    @(negedge clk);
    check("nw_drain", 32'(bus.oWbValid), 32'd0);
    set_defaults();

    // Counter saturation over 20 contended cycles.
    tick();
    rst = 1'b1;
    tick();
    rst          = 1'b0;
    bus.iOpValid = 4'b1111;
    @(negedge clk);
    check("sat_start", 32'(oConflictCnt), 32'd0);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      check("sat_cnt", 32'(oConflictCnt), 32'((n < 15) ? n : 15));
    end

    // Reset mid-operation: entry discarded, pipe 1 held, then granted first.
    tick();
    bus.iOpValid = 4'b0010;
    rst          = 1'b1;
    @(negedge clk);
    check("mr_stall_pre", 32'(bus.oStall), 32'h2);
    check("mr_valid_pre", 32'(bus.oWbValid), 32'd1);
    tick();
    @(negedge clk);
    check("mr_valid", 32'(bus.oWbValid), 32'd0);
    check("mr_cnt", 32'(oConflictCnt), 32'd0);
    check("mr_stall", 32'(bus.oStall), 32'h2);
    tick();
    rst          = 1'b0;
    bus.iOpValid = 4'b1010;
    @(negedge clk);
    check("mr_release_stall", 32'(bus.oStall), 32'h8);
    tick();
    bus.iOpValid = '0;
    @(negedge clk);
    check("mr_first_rid", 32'(bus.oWbRID), 32'd9);
    check("mr_first_valid", 32'(bus.oWbValid), 32'd1);
    tick();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
